stream_accumulator: RTL and testbench

- Parametrised successor to the 8-bit valid/ready accumulator sink.
- Consumes an unsigned sample stream over a valid/ready input and keeps a running total.
- Also forms per-window sums over a runtime-programmable number of samples and emits each sum on a valid/ready output stream.
- Sits downstream of a sample source (for example the 8-bit counter); can feed a further sink or a host-readout stage.

---
 rtl/stream_accumulator_if.sv | 12 +
 rtl/stream_accumulator.sv | 90 +++++++++
 tb/tb_stream_accumulator.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/stream_accumulator_if.sv
// Valid/ready stream bundle shared by the sample input and the window-sum output.
// Transfer happens on a rising clock edge with valid && ready both high; a master holds valid/data until accepted.
interface stream_accumulator_if #(
  parameter int WIDTH = 8
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/stream_accumulator.sv
// Running-total and windowed-sum accumulator for an unsigned valid/ready sample stream.
// Window sums leave on a second valid/ready stream; input stalls only while a sum is unacknowledged.
module stream_accumulator #(
   parameter int DATA_WIDTH   = 8,
   parameter int ACC_WIDTH    = 16,
   parameter int WINDOW_WIDTH = 8,
   parameter bit SATURATE     = 1'b0
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    clear,
   input  logic [WINDOW_WIDTH-1:0] window_length,
   stream_accumulator_if.slave     samples,
   stream_accumulator_if.master    sums,
   output logic [ACC_WIDTH-1:0]    accumulated,
   output logic                    overflow
);

   logic [ACC_WIDTH-1:0]    win_q;
   logic [WINDOW_WIDTH-1:0] cnt_q;
   logic [WINDOW_WIDTH-1:0] len_q;
   logic                    sum_valid_q;
   logic [ACC_WIDTH-1:0]    sum_q;

   logic                    accept;
   logic [ACC_WIDTH-1:0]    sample_ext;
   logic [ACC_WIDTH:0]      acc_full;
   logic [ACC_WIDTH:0]      win_full;
   logic [WINDOW_WIDTH-1:0] eff_len;
   logic [WINDOW_WIDTH-1:0] cnt_inc;

   // Carry bit of a widened sum decides between wrap and clamp.
   function automatic logic [ACC_WIDTH-1:0] limit(input logic [ACC_WIDTH:0] full);
      if (SATURATE && full[ACC_WIDTH]) return '1;
      return full[ACC_WIDTH-1:0];
   endfunction

   assign samples.ready = (len_q == '0) || !(sum_valid_q && !sums.ready);
   assign accept        = samples.valid && samples.ready;

   assign sample_ext = ACC_WIDTH'(samples.data);
   assign acc_full   = {1'b0, accumulated} + {1'b0, sample_ext};
   assign win_full   = {1'b0, win_q} + {1'b0, sample_ext};

   // The length in force is the live input on a window's first sample, the latched copy afterwards.
   assign eff_len = (cnt_q == '0) ? window_length : len_q;
   assign cnt_inc = cnt_q + WINDOW_WIDTH'(1);

   assign sums.valid = sum_valid_q;
   assign sums.data  = sum_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         accumulated <= '0;
         overflow    <= 1'b0;
         win_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
         sum_valid_q <= 1'b0;
         sum_q       <= '0;
      end else begin
         if (sum_valid_q && sums.ready) sum_valid_q <= 1'b0;

         // clear leaves a pending output beat alone and swallows any coincident sample.
         if (clear) begin
            accumulated <= '0;
            overflow    <= 1'b0;
            win_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
         end else if (accept) begin
            accumulated <= limit(acc_full);
            if (acc_full[ACC_WIDTH]) overflow <= 1'b1;
            if (cnt_q == '0) len_q <= window_length;
            if (eff_len != '0) begin
               if (cnt_inc == eff_len) begin
                  sum_q       <= limit(win_full);
                  sum_valid_q <= 1'b1;
                  win_q       <= '0;
                  cnt_q       <= '0;
               end else begin
                  win_q <= limit(win_full);
                  cnt_q <= cnt_inc;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed bench: a wrapping and a saturating instance share one stimulus stream.
module tb_stream_accumulator;

   logic        clock;
   logic        reset_n;
   logic        clear;
   logic [7:0]  window_length;
   logic        valid;
   logic [7:0]  data;
   logic        out_ready;
   logic [15:0] acc0, acc1;
   logic        ovf0, ovf1;

   int n_checks = 0;
   int n_fail   = 0;

   stream_accumulator_if #(.WIDTH(8))  s0 ();
   stream_accumulator_if #(.WIDTH(16)) r0 ();
   stream_accumulator_if #(.WIDTH(8))  s1 ();
   stream_accumulator_if #(.WIDTH(16)) r1 ();

   assign s0.valid = valid;
   assign s0.data  = data;
   assign r0.ready = out_ready;
   assign s1.valid = valid;
   assign s1.data  = data;
   assign r1.ready = out_ready;

   stream_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .WINDOW_WIDTH(8), .SATURATE(1'b0)) dut_wrap (
      .clock(clock), .reset_n(reset_n), .clear(clear), .window_length(window_length),
      .samples(s0), .sums(r0), .accumulated(acc0), .overflow(ovf0));

   stream_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .WINDOW_WIDTH(8), .SATURATE(1'b1)) dut_sat (
      .clock(clock), .reset_n(reset_n), .clear(clear), .window_length(window_length),
      .samples(s1), .sums(r1), .accumulated(acc1), .overflow(ovf1));

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Presents one sample and returns 1 ns after the edge that accepted it.
   task automatic send(input logic [7:0] d);
      logic rdy;
      valid = 1'b1;
      data  = d;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         rdy = s0.ready;
         @(posedge clock);
         #1;
         if (rdy) return;
      end
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout got no_accept want accept of %0d", d);
   endtask

   task automatic do_clear();
      valid = 1'b0;
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; clear = 1'b0; window_length = 8'd0;
      valid = 1'b0; data = 8'd0; out_ready = 1'b0;
      repeat (2) tick();
      n_checks++; if (acc0 !== 16'd0) begin n_fail++; $display("FAIL reset_acc got %0h want 0", acc0); end
      n_checks++; if (ovf0 !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", ovf0); end
      n_checks++; if (r0.valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", r0.valid); end
      n_checks++; if (r0.data !== 16'd0) begin n_fail++; $display("FAIL reset_out_sum got %0h want 0", r0.data); end
      n_checks++; if (s0.ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", s0.ready); end
      n_checks++; if (acc1 !== 16'd0 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL reset_sat got %0h/%b want 0/0", acc1, ovf1); end
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_running();
      logic [15:0] exp_acc;
      exp_acc = 16'd0;
      window_length = 8'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         n_checks++; if (s0.ready !== 1'b1) begin n_fail++; $display("FAIL running_ready got %b want 1", s0.ready); end
         send(8'(i));
         exp_acc = exp_acc + 16'(i);
         n_checks++; if (acc0 !== exp_acc) begin n_fail++; $display("FAIL running_acc got %0d want %0d", acc0, exp_acc); end
         n_checks++; if (r0.valid !== 1'b0) begin n_fail++; $display("FAIL running_no_beat got %b want 0", r0.valid); end
      end
      valid = 1'b0;
      n_checks++; if (acc0 !== 16'h002D) begin n_fail++; $display("FAIL running_total got %0h want 002d", acc0); end
   endtask

   task automatic test_window();
      do_clear();
      window_length = 8'd4;
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) send(8'(i));
      n_checks++; if (r0.valid !== 1'b1 || r0.data !== 16'd10) begin n_fail++; $display("FAIL window_beat1 got %b/%0d want 1/10", r0.valid, r0.data); end
      send(8'd5);
      n_checks++; if (r0.valid !== 1'b0) begin n_fail++; $display("FAIL window_beat1_drop got %b want 0", r0.valid); end
      for (int i = 6; i <= 8; i++) send(8'(i));
      valid = 1'b0;
      n_checks++; if (r0.valid !== 1'b1 || r0.data !== 16'd26) begin n_fail++; $display("FAIL window_beat2 got %b/%0d want 1/26", r0.valid, r0.data); end
      tick();
      n_checks++; if (r0.valid !== 1'b0) begin n_fail++; $display("FAIL window_beat2_drop got %b want 0", r0.valid); end
      n_checks++; if (acc0 !== 16'd36) begin n_fail++; $display("FAIL window_acc got %0d want 36", acc0); end
   endtask

   task automatic test_backpressure();
      do_clear();
      window_length = 8'd4;
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) send(8'(i));
      out_ready = 1'b0;
      for (int i = 6; i <= 8; i++) send(8'(i));
      valid = 1'b1;
      data  = 8'd9;
      #1;
      n_checks++; if (s0.ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready_low got %b want 0", s0.ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++; if (r0.valid !== 1'b1 || r0.data !== 16'd26) begin n_fail++; $display("FAIL bp_hold got %b/%0d want 1/26", r0.valid, r0.data); end
         n_checks++; if (s0.ready !== 1'b0 || acc0 !== 16'd36) begin n_fail++; $display("FAIL bp_stall got %b/%0d want 0/36", s0.ready, acc0); end
      end
      out_ready = 1'b1;
      #1;
      n_checks++; if (s0.ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_comb got %b want 1", s0.ready); end
      send(8'd9);
      n_checks++; if (r0.valid !== 1'b0 || acc0 !== 16'd45) begin n_fail++; $display("FAIL bp_resume got %b/%0d want 0/45", r0.valid, acc0); end
      for (int i = 10; i <= 12; i++) send(8'(i));
      valid = 1'b0;
      n_checks++; if (r0.valid !== 1'b1 || r0.data !== 16'd42) begin n_fail++; $display("FAIL bp_next_window got %b/%0d want 1/42", r0.valid, r0.data); end
      tick();
   endtask

   task automatic test_saturate();
      do_clear();
      window_length = 8'd0;
      out_ready = 1'b1;
      for (int i = 0; i < 256; i++) send(8'hFF);
      send(8'd240);
      n_checks++; if (acc0 !== 16'hFFF0 || ovf0 !== 1'b0) begin n_fail++; $display("FAIL sat_pre_wrap got %0h/%b want fff0/0", acc0, ovf0); end
      n_checks++; if (acc1 !== 16'hFFF0 || ovf1 !== 1'b0) begin n_fail++; $display("FAIL sat_pre_sat got %0h/%b want fff0/0", acc1, ovf1); end
      send(8'h20);
      n_checks++; if (acc0 !== 16'h0010 || ovf0 !== 1'b1) begin n_fail++; $display("FAIL sat_wrap got %0h/%b want 0010/1", acc0, ovf0); end
      n_checks++; if (acc1 !== 16'hFFFF || ovf1 !== 1'b1) begin n_fail++; $display("FAIL sat_clamp got %0h/%b want ffff/1", acc1, ovf1); end
      send(8'h01);
      valid = 1'b0;
      n_checks++; if (acc0 !== 16'h0011 || ovf0 !== 1'b1) begin n_fail++; $display("FAIL sat_wrap_sticky got %0h/%b want 0011/1", acc0, ovf0); end
      n_checks++; if (acc1 !== 16'hFFFF || ovf1 !== 1'b1) begin n_fail++; $display("FAIL sat_clamp_hold got %0h/%b want ffff/1", acc1, ovf1); end
      do_clear();
      n_checks++; if (ovf0 !== 1'b0 || acc1 !== 16'd0) begin n_fail++; $display("FAIL sat_clear got %b/%0h want 0/0", ovf0, acc1); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vals [3];
      vals[0] = 8'd3; vals[1] = 8'd5; vals[2] = 8'd7;
      do_clear();
      window_length = 8'd1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (s0.ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready got %b want 1", s0.ready); end
         send(vals[i]);
         n_checks++; if (r0.valid !== 1'b1 || r0.data !== 16'(vals[i])) begin n_fail++; $display("FAIL b2b_beat got %b/%0d want 1/%0d", r0.valid, r0.data, vals[i]); end
      end
      valid = 1'b0;
      tick();
      n_checks++; if (r0.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drop got %b want 0", r0.valid); end
   endtask

   task automatic test_clear_and_reset();
      do_clear();
      window_length = 8'd4;
      out_ready = 1'b1;
      send(8'd1);
      send(8'd2);
      clear = 1'b1;
      send(8'd50);
      clear = 1'b0;
      n_checks++; if (acc0 !== 16'd0 || r0.valid !== 1'b0) begin n_fail++; $display("FAIL clr_mid got %0d/%b want 0/0", acc0, r0.valid); end
      for (int i = 1; i <= 3; i++) send(8'(i));
      n_checks++; if (r0.valid !== 1'b0) begin n_fail++; $display("FAIL clr_no_early_beat got %b want 0", r0.valid); end
      send(8'd4);
      valid = 1'b0;
      out_ready = 1'b0;
      n_checks++; if (r0.valid !== 1'b1 || r0.data !== 16'd10 || acc0 !== 16'd10) begin n_fail++; $display("FAIL clr_window got %b/%0d/%0d want 1/10/10", r0.valid, r0.data, acc0); end
      tick();
      n_checks++; if (r0.valid !== 1'b1) begin n_fail++; $display("FAIL rst_pending got %b want 1", r0.valid); end
      #2;
      reset_n = 1'b0;
      #1;
      n_checks++; if (r0.valid !== 1'b0 || r0.data !== 16'd0 || acc0 !== 16'd0) begin n_fail++; $display("FAIL rst_async got %b/%0d/%0d want 0/0/0", r0.valid, r0.data, acc0); end
      tick();
      reset_n = 1'b1;
      tick();
      n_checks++; if (s0.ready !== 1'b1 || r0.valid !== 1'b0) begin n_fail++; $display("FAIL rst_after got %b/%b want 1/0", s0.ready, r0.valid); end
   endtask

   initial begin
      test_reset();
      test_running();
      test_window();
      test_backpressure();
      test_saturate();
      test_back_to_back();
      test_clear_and_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
